// File: rtl/rx_command_parser.sv
// Byte-stream command parser: frames SYNC, CMD, P0..P7, CHK into an opcode plus
// 64-bit payload, checked by XOR, and offered on a valid/ready port.
module rx_command_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_new_i,
    output logic [7:0]  cmd_o,
    output logic [63:0] payload_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  err_count_o,
    output logic        busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       shadow_cmd;
    logic [63:0]      shadow_payload;
    logic [7:0]       checksum;
    logic [2:0]       byte_cnt;
    logic [CNT_W-1:0] idle_cnt;

    logic in_frame;
    logic timeout;
    logic err_evt;
    logic cap_cmd;
    logic cap_byte;
    logic accept;

    assign in_frame = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_CHECK);
    // A strobe in the expiring cycle wins over the timeout.
    assign timeout  = in_frame && !rx_new_i && (idle_cnt == IDLE_LAST);

    always_comb begin
        state_next = state;
        err_evt    = 1'b0;
        cap_cmd    = 1'b0;
        cap_byte   = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_new_i && (rx_data_i == SYNC_BYTE))
                    state_next = S_CMD;
            end
            S_CMD: begin
                if (rx_new_i) begin
                    cap_cmd    = 1'b1;
                    state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rx_new_i) begin
                    cap_byte = 1'b1;
                    if (byte_cnt == 3'd7)
                        state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rx_new_i) begin
                    if (rx_data_i == checksum) begin
                        accept     = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        err_evt    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // Bytes arriving while a command is pending are overruns, even on the handshake cycle.
                if (rx_new_i)
                    err_evt = 1'b1;
                if (cmd_valid_o && cmd_ready_i)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (timeout) begin
            err_evt    = 1'b1;
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            busy_o <= 1'b0;
        end else begin
            state <= state_next;
            busy_o <= (state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_cmd     <= '0;
            shadow_payload <= '0;
            checksum       <= '0;
            byte_cnt       <= '0;
            idle_cnt       <= '0;
        end else begin
            if (cap_cmd) begin
                shadow_cmd <= rx_data_i;
                checksum   <= rx_data_i;
                byte_cnt   <= '0;
            end else if (cap_byte) begin
                shadow_payload <= {shadow_payload[55:0], rx_data_i};
                checksum       <= checksum ^ rx_data_i;
                byte_cnt       <= byte_cnt + 3'd1;
            end
            if (!in_frame || rx_new_i || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_o       <= '0;
            payload_o   <= '0;
            cmd_valid_o <= 1'b0;
            err_count_o <= '0;
        end else begin
            if (accept) begin
                cmd_o       <= shadow_cmd;
                payload_o   <= shadow_payload;
                cmd_valid_o <= 1'b1;
            end else if (cmd_valid_o && cmd_ready_i) begin
                cmd_valid_o <= 1'b0;
            end
            if (err_evt && (err_count_o != 8'hFF))
                err_count_o <= err_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_command_parser.sv
// Directed bench for rx_command_parser: framing, checksum, timeout, overrun,
// garbage rejection, asynchronous reset and error-count saturation.
module tb_rx_command_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_new;
    logic [7:0]  cmd;
    logic [63:0] payload;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  err_count;
    logic        busy;

    int checks;
    int failures;
    int exp_err;

    rx_command_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .rx_data_i   (rx_data),
        .rx_new_i    (rx_new),
        .cmd_o       (cmd),
        .payload_o   (payload),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .err_count_o (err_count),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_new  = 1'b1;
        @(negedge clk);
        rx_new  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [63:0] p, input logic corrupt);
        logic [7:0] chk;
        chk = c;
        send_byte(8'hA5);
        send_byte(c);
        for (int i = 7; i >= 0; i--) begin
            send_byte(p[i*8 +: 8]);
            chk = chk ^ p[i*8 +: 8];
        end
        send_byte(corrupt ? ~chk : chk);
    endtask

    task automatic handshake();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_err   = 0;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_new    = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd", 64'(cmd), 64'h0);
        check_eq("rst_payload", payload, 64'h0);
        check_eq("rst_valid", 64'(cmd_valid), 64'h0);
        check_eq("rst_err", 64'(err_count), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Valid frame from the test plan, with the explicit CHK of 01.
        send_byte(8'hA5);
        check_eq("busy_after_sync", 64'(busy), 64'h1);
        send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        send_byte(8'h89); send_byte(8'hAB); send_byte(8'hCD);
        check_eq("valid_before_chk", 64'(cmd_valid), 64'h0);
        send_byte(8'hEF);
        send_byte(8'h01);
        check_eq("valid_after_chk", 64'(cmd_valid), 64'h1);
        check_eq("cmd_after_chk", 64'(cmd), 64'h01);
        check_eq("payload_after_chk", payload, 64'h0123456789ABCDEF);
        repeat (100) @(negedge clk);
        check_eq("valid_hold100", 64'(cmd_valid), 64'h1);
        check_eq("payload_hold100", payload, 64'h0123456789ABCDEF);
        handshake();
        check_eq("valid_after_ready", 64'(cmd_valid), 64'h0);
        check_eq("busy_after_ready", 64'(busy), 64'h0);
        check_eq("err_after_valid", 64'(err_count), 64'h0);

        // Bad checksum: outputs keep the previous command.
        send_frame(8'h01, 64'h0123456789ABCDEF, 1'b1);
        exp_err++;
        check_eq("bad_valid", 64'(cmd_valid), 64'h0);
        check_eq("bad_err", 64'(err_count), 64'(exp_err));
        check_eq("bad_cmd", 64'(cmd), 64'h01);
        check_eq("bad_payload", payload, 64'h0123456789ABCDEF);
        check_eq("bad_busy", 64'(busy), 64'h0);

        // Timeout after a partial frame: 99 idle cycles keep busy, the 100th abandons.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        repeat (99) @(negedge clk);
        check_eq("to_busy_99", 64'(busy), 64'h1);
        check_eq("to_err_99", 64'(err_count), 64'(exp_err));
        @(negedge clk);
        exp_err++;
        check_eq("to_busy_100", 64'(busy), 64'h0);
        check_eq("to_err_100", 64'(err_count), 64'(exp_err));
        send_frame(8'h03, 64'hDEADBEEF00C0FFEE, 1'b0);
        check_eq("to_next_valid", 64'(cmd_valid), 64'h1);
        check_eq("to_next_cmd", 64'(cmd), 64'h03);
        check_eq("to_next_payload", payload, 64'hDEADBEEF00C0FFEE);
        handshake();

        // Overrun while a command is pending, then sync colliding with the handshake.
        send_frame(8'h04, 64'h1122334455667788, 1'b0);
        send_byte(8'h10); send_byte(8'hA5); send_byte(8'h20); send_byte(8'h30);
        exp_err += 4;
        check_eq("ovr_err", 64'(err_count), 64'(exp_err));
        check_eq("ovr_valid", 64'(cmd_valid), 64'h1);
        check_eq("ovr_payload", payload, 64'h1122334455667788);
        rx_data   = 8'hA5;
        rx_new    = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        rx_new    = 1'b0;
        cmd_ready = 1'b0;
        exp_err++;
        check_eq("hs_sync_valid", 64'(cmd_valid), 64'h0);
        check_eq("hs_sync_busy", 64'(busy), 64'h0);
        check_eq("hs_sync_err", 64'(err_count), 64'(exp_err));

        // Garbage then a back-to-back frame at full rate.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check_eq("garbage_busy", 64'(busy), 64'h0);
        send_frame(8'h05, 64'hA5A5A5A5A5A5A5A5, 1'b0);
        check_eq("b2b_valid", 64'(cmd_valid), 64'h1);
        check_eq("b2b_cmd", 64'(cmd), 64'h05);
        check_eq("b2b_payload", payload, 64'hA5A5A5A5A5A5A5A5);
        check_eq("b2b_err", 64'(err_count), 64'(exp_err));
        handshake();

        // Asynchronous reset mid-payload.
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h11); send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cmd", 64'(cmd), 64'h0);
        check_eq("arst_payload", payload, 64'h0);
        check_eq("arst_err", 64'(err_count), 64'h0);
        check_eq("arst_busy", 64'(busy), 64'h0);
        check_eq("arst_valid", 64'(cmd_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturation of the error counter.
        for (int i = 0; i < 254; i++)
            send_frame(8'h09, 64'(i), 1'b1);
        check_eq("sat_254", 64'(err_count), 64'hFE);
        send_frame(8'h09, 64'h0, 1'b1);
        check_eq("sat_255", 64'(err_count), 64'hFF);
        for (int i = 0; i < 45; i++)
            send_frame(8'h09, 64'(i), 1'b1);
        check_eq("sat_300", 64'(err_count), 64'hFF);
        check_eq("sat_cmd", 64'(cmd), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
